// File: rtl/cipher_stream_ctrl.sv
// cipher_stream_ctrl: arbitrates NUM_CH requesters onto a single cipher core.
// A round-robin grant launches the core, beats are counted down on core_valid,
// and the owner channel sees done (or error on an idle timeout) until it acks.
module cipher_stream_ctrl #(
    parameter int NUM_CH    = 2,
    parameter int MAX_BEATS = 16,
    parameter int TIMEOUT   = 255,
    localparam int LW = $clog2(MAX_BEATS + 1),
    localparam int TW = $clog2(TIMEOUT + 1)
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [NUM_CH-1:0] req,
    input  logic [LW-1:0]     len,
    input  logic [NUM_CH-1:0] ack,
    input  logic              core_valid,
    output logic [NUM_CH-1:0] grant,
    output logic              core_start,
    output logic [NUM_CH-1:0] done,
    output logic              error,
    output logic              busy,
    output logic [LW-1:0]     beats_left,
    output logic [2:0]        state_out
);

    localparam int RW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START      = 3'd1,
        PROCESSING = 3'd2,
        DONE       = 3'd3,
        ERROR      = 3'd4
    } state_t;

    state_t              state;
    logic [RW-1:0]       rr;
    logic [TW-1:0]       tcnt;

    logic [2*NUM_CH-1:0] req_dbl;
    logic [NUM_CH-1:0]   req_rot;
    logic                found;
    logic [RW-1:0]       off;
    logic [RW:0]         sum;
    logic [RW:0]         nxt;
    logic [RW-1:0]       pick;
    logic [RW-1:0]       rr_nxt;
    logic [NUM_CH-1:0]   pick_oh;
    logic [LW-1:0]       len_clamp;

    assign state_out = state;

    // Requests rotated so that bit 0 is the channel at the rr pointer; the
    // first set bit is then the round-robin winner, offset from rr.
    assign req_dbl = {req, req};
    assign req_rot = NUM_CH'(req_dbl >> rr);

    // Round-robin pick, next pointer and clamped beat count for a new grant
    always_comb begin
        found = 1'b0;
        off   = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (!found && req_rot[i]) begin
                found = 1'b1;
                off   = RW'(i);
            end
        end
        sum = {1'b0, rr} + {1'b0, off};
        if (sum >= (RW+1)'(NUM_CH))
            sum = sum - (RW+1)'(NUM_CH);
        pick = sum[RW-1:0];
        nxt  = {1'b0, pick} + 1'b1;
        if (nxt >= (RW+1)'(NUM_CH))
            nxt = '0;
        rr_nxt    = nxt[RW-1:0];
        pick_oh   = NUM_CH'(1) << pick;
        len_clamp = (len > LW'(MAX_BEATS)) ? LW'(MAX_BEATS) : len;
    end

    // Transaction FSM with all outputs registered alongside the state
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state      <= IDLE;
            rr         <= '0;
            tcnt       <= '0;
            grant      <= '0;
            core_start <= 1'b0;
            done       <= '0;
            error      <= 1'b0;
            busy       <= 1'b0;
            beats_left <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        grant <= pick_oh;
                        rr    <= rr_nxt;
                        busy  <= 1'b1;
                        tcnt  <= '0;
                        if (len_clamp != '0) begin
                            state      <= START;
                            core_start <= 1'b1;
                            beats_left <= len_clamp;
                        end else begin
                            state      <= DONE;
                            done       <= pick_oh;
                            beats_left <= '0;
                        end
                    end
                end
                START: begin
                    core_start <= 1'b0;
                    state      <= PROCESSING;
                end
                PROCESSING: begin
                    // a beat in the same cycle as the timeout boundary wins
                    if (core_valid) begin
                        tcnt       <= '0;
                        beats_left <= beats_left - 1'b1;
                        if (beats_left == LW'(1)) begin
                            state <= DONE;
                            done  <= grant;
                        end
                    end else if (tcnt == TW'(TIMEOUT - 1)) begin
                        state <= ERROR;
                        error <= 1'b1;
                        tcnt  <= '0;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                DONE: begin
                    if (|(ack & grant)) begin
                        state      <= IDLE;
                        grant      <= '0;
                        done       <= '0;
                        busy       <= 1'b0;
                        beats_left <= '0;
                    end
                end
                ERROR: begin
                    if (|(ack & grant)) begin
                        state      <= IDLE;
                        grant      <= '0;
                        error      <= 1'b0;
                        busy       <= 1'b0;
                        beats_left <= '0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    grant      <= '0;
                    core_start <= 1'b0;
                    done       <= '0;
                    error      <= 1'b0;
                    busy       <= 1'b0;
                    beats_left <= '0;
                    tcnt       <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cipher_stream_ctrl.sv
// Testbench for cipher_stream_ctrl: directed transactions; expected output
// snapshots are queued by the stimulus and popped by a monitor whenever the
// DUT raises core_start, done or error.
module tb_cipher_stream_ctrl;

    localparam int NUM_CH    = 2;
    localparam int MAX_BEATS = 16;
    localparam int TIMEOUT   = 8;
    localparam int LW        = 5;

    logic              clk = 1'b0;
    logic              nrst;
    logic [NUM_CH-1:0] req;
    logic [LW-1:0]     len;
    logic [NUM_CH-1:0] ack;
    logic              core_valid;
    logic [NUM_CH-1:0] grant;
    logic              core_start;
    logic [NUM_CH-1:0] done;
    logic              error;
    logic              busy;
    logic [LW-1:0]     beats_left;
    logic [2:0]        state_out;

    always #5 clk = ~clk;

    cipher_stream_ctrl #(
        .NUM_CH    (NUM_CH),
        .MAX_BEATS (MAX_BEATS),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk        (clk),
        .nrst       (nrst),
        .req        (req),
        .len        (len),
        .ack        (ack),
        .core_valid (core_valid),
        .grant      (grant),
        .core_start (core_start),
        .done       (done),
        .error      (error),
        .busy       (busy),
        .beats_left (beats_left),
        .state_out  (state_out)
    );

    typedef struct packed {
        logic [2:0] st;
        logic [1:0] gnt;
        logic [1:0] dn;
        logic       err;
        logic [4:0] bl;
        logic       cs;
    } snap_t;

    snap_t      exp_q[$];
    snap_t      act_s;
    snap_t      exp_s;
    logic [1:0] prev_dn  = '0;
    logic       prev_err = 1'b0;
    int         checks   = 0;
    int         errors   = 0;

    function automatic snap_t mk(input int st, input int gnt, input int dn,
                                 input int err, input int bl, input int cs);
        snap_t s;
        s.st  = 3'(st);
        s.gnt = 2'(gnt);
        s.dn  = 2'(dn);
        s.err = 1'(err);
        s.bl  = 5'(bl);
        s.cs  = 1'(cs);
        return s;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every core_start cycle, done rise or error rise consumes one
    // expected snapshot.
    always @(negedge clk) begin
        act_s = {state_out, grant, done, error, beats_left, core_start};
        if (core_start || (done != 2'b00 && prev_dn == 2'b00) || (error && !prev_err)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: got st=%0d gnt=%b dn=%b err=%b bl=%0d cs=%b, nothing expected",
                         act_s.st, act_s.gnt, act_s.dn, act_s.err, act_s.bl, act_s.cs);
            end else begin
                exp_s = exp_q.pop_front();
                if (act_s !== exp_s) begin
                    errors++;
                    $display("FAIL event: got st=%0d gnt=%b dn=%b err=%b bl=%0d cs=%b expected st=%0d gnt=%b dn=%b err=%b bl=%0d cs=%b",
                             act_s.st, act_s.gnt, act_s.dn, act_s.err, act_s.bl, act_s.cs,
                             exp_s.st, exp_s.gnt, exp_s.dn, exp_s.err, exp_s.bl, exp_s.cs);
                end
            end
        end
        prev_dn  = done;
        prev_err = error;
    end

    initial begin
        nrst = 1'b0; req = '0; len = '0; ack = '0; core_valid = 1'b0;
        tick; tick;
        chk("rst_state", state_out, 0);
        chk("rst_grant", grant, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_busy", busy, 0);
        chk("rst_beats", beats_left, 0);
        chk("rst_core_start", core_start, 0);
        nrst = 1'b1;
        tick;

        // basic 3-beat transaction on channel 0
        req = 2'b01; len = 5'd3;
        exp_q.push_back(mk(1, 1, 0, 0, 3, 1));
        tick;
        chk("t1_grant", grant, 1);
        chk("t1_core_start", core_start, 1);
        chk("t1_beats3", beats_left, 3);
        chk("t1_busy", busy, 1);
        req = 2'b00;
        tick;
        chk("t1_proc", state_out, 2);
        chk("t1_start_one_cycle", core_start, 0);
        core_valid = 1'b1;
        tick; chk("t1_beats2", beats_left, 2);
        tick; chk("t1_beats1", beats_left, 1);
        exp_q.push_back(mk(3, 1, 1, 0, 0, 1'b0));
        tick;
        chk("t1_beats0", beats_left, 0);
        chk("t1_done_state", state_out, 3);
        core_valid = 1'b0;
        tick; chk("t1_done_hold", done, 1);
        ack = 2'b01;
        tick;
        chk("t1_idle", state_out, 0);
        chk("t1_grant_drop", grant, 0);
        chk("t1_done_clear", done, 0);
        chk("t1_busy_clear", busy, 0);
        ack = 2'b00;

        // zero-length transaction on channel 1 goes straight to DONE
        req = 2'b10; len = 5'd0;
        exp_q.push_back(mk(3, 2, 2, 0, 0, 0));
        tick;
        chk("t3_done_state", state_out, 3);
        chk("t3_no_start", core_start, 0);
        chk("t3_beats0", beats_left, 0);
        req = 2'b00; ack = 2'b01; core_valid = 1'b1;
        tick;
        chk("t3_nonowner_ack", state_out, 3);
        chk("t3_done_hold", done, 2);
        ack = 2'b10; core_valid = 1'b0;
        tick;
        chk("t3_idle", state_out, 0);
        ack = 2'b00;

        // both requesting: round-robin alternates 01 then 10
        req = 2'b11; len = 5'd1;
        exp_q.push_back(mk(1, 1, 0, 0, 1, 1));
        tick;
        chk("t2_first_grant", grant, 1);
        core_valid = 1'b1;
        tick;
        chk("t2_cv_in_start_ignored", beats_left, 1);
        chk("t2_proc", state_out, 2);
        exp_q.push_back(mk(3, 1, 1, 0, 0, 0));
        tick;
        core_valid = 1'b0; ack = 2'b01;
        tick;
        chk("t2_no_regrant_grant", grant, 0);
        chk("t2_no_regrant_state", state_out, 0);
        ack = 2'b00;
        exp_q.push_back(mk(1, 2, 0, 0, 1, 1));
        tick;
        chk("t2_second_grant", grant, 2);
        req = 2'b00;
        tick;
        core_valid = 1'b1;
        exp_q.push_back(mk(3, 2, 2, 0, 0, 0));
        tick;
        core_valid = 1'b0;
        chk("t2_second_done", state_out, 3);
        ack = 2'b10;
        tick;
        ack = 2'b00;
        chk("t2_idle", state_out, 0);

        // timeout after 8 idle PROCESSING cycles
        req = 2'b01; len = 5'd4;
        exp_q.push_back(mk(1, 1, 0, 0, 4, 1));
        tick;
        req = 2'b00;
        tick;
        repeat (7) tick;
        chk("t4_proc_at_7", state_out, 2);
        chk("t4_no_error_at_7", error, 0);
        exp_q.push_back(mk(4, 1, 0, 1, 4, 0));
        tick;
        chk("t4_error_state", state_out, 4);
        chk("t4_error_flag", error, 1);
        ack = 2'b10;
        tick;
        chk("t4_nonowner_ack_state", state_out, 4);
        chk("t4_nonowner_ack_error", error, 1);
        ack = 2'b01;
        tick;
        chk("t4_idle", state_out, 0);
        chk("t4_error_clear", error, 0);
        ack = 2'b00;

        // len clamp and core_valid winning at the timeout boundary
        req = 2'b10; len = 5'd20;
        exp_q.push_back(mk(1, 2, 0, 0, 16, 1));
        tick;
        chk("t5_clamp", beats_left, 16);
        req = 2'b00;
        tick;
        repeat (7) tick;
        core_valid = 1'b1;
        tick;
        core_valid = 1'b0;
        chk("t5_cv_wins_state", state_out, 2);
        chk("t5_cv_wins_error", error, 0);
        chk("t5_beats15", beats_left, 15);
        repeat (7) tick;
        chk("t5_count_cleared", state_out, 2);
        exp_q.push_back(mk(4, 2, 0, 1, 15, 0));
        tick;
        chk("t5_error_state", state_out, 4);
        ack = 2'b10;
        tick;
        ack = 2'b00;
        chk("t5_idle", state_out, 0);

        // asynchronous reset mid-transaction, then channel 0 first again
        req = 2'b01; len = 5'd5;
        exp_q.push_back(mk(1, 1, 0, 0, 5, 1));
        tick;
        req = 2'b00;
        tick;
        chk("t6_beats5", beats_left, 5);
        chk("t6_proc", state_out, 2);
        #2 nrst = 1'b0;
        #1;
        chk("t6_rst_state", state_out, 0);
        chk("t6_rst_grant", grant, 0);
        chk("t6_rst_done", done, 0);
        chk("t6_rst_error", error, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_beats", beats_left, 0);
        chk("t6_rst_core_start", core_start, 0);
        tick;
        nrst = 1'b1;
        req = 2'b11; len = 5'd1;
        exp_q.push_back(mk(1, 1, 0, 0, 1, 1));
        tick;
        chk("t6_rr_reset_grant", grant, 1);
        req = 2'b00;
        tick;
        core_valid = 1'b1;
        exp_q.push_back(mk(3, 1, 1, 0, 0, 0));
        tick;
        core_valid = 1'b0; ack = 2'b01;
        tick;
        ack = 2'b00;
        chk("t6_idle", state_out, 0);

        tick; tick;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
